// File: rtl/frame_store_iq.sv
// frame_store_iq: byte-wide requester bridge onto a 16-bit arbitrated frame-store bus.
// Define IQ_TIMEOUT_EN to enable the 255-cycle access timeout and the sticky iq_err flag.
module frame_store_iq (
  input  logic        clk,
  input  logic        nreset,
  input  logic        iq_req,
  output logic        iq_ack,
  input  logic [19:0] iq_address,
  input  logic        iq_rnw,
  input  logic [7:0]  data_from_iq,
  output logic [7:0]  data_to_iq,
  output logic        iq_busy,
  output logic        fs_req,
  input  logic        fs_gnt,
  output logic [18:0] fs_address,
  output logic        fs_rnw,
  output logic [1:0]  fs_nbs,
  output logic [15:0] fs_wdata,
  input  logic [15:0] fs_rdata,
  input  logic        fs_ack,
  output logic        iq_err,
  input  logic        iq_err_clr
);
  typedef enum logic [1:0] {IDLE, ARB, ACCESS, ACK} state_t;
  state_t      state_q, state_d;
  logic [18:0] fs_address_q, fs_address_d;
  logic        fs_rnw_q, fs_rnw_d;
  logic [1:0]  fs_nbs_q, fs_nbs_d;
  logic [15:0] fs_wdata_q, fs_wdata_d;
  logic [7:0]  data_q, data_d;
  logic        to_fire;
`ifdef IQ_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  // Timeout only fires when the current state is not about to make progress.
  assign to_fire = cnt_q == 8'hFF && ((state_q == ARB && !fs_gnt) || (state_q == ACCESS && !fs_ack));
  always_comb begin
    cnt_d = (state_q == IDLE && iq_req) ? 8'h00 :
            (state_q == ARB || state_q == ACCESS) ? cnt_q + 8'h01 : cnt_q;
    err_d = to_fire ? 1'b1 : iq_err_clr ? 1'b0 : err_q;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign iq_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = iq_err_clr;
  assign to_fire = 1'b0;
  assign iq_err = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    fs_address_d = fs_address_q;
    fs_rnw_d     = fs_rnw_q;
    fs_nbs_d     = fs_nbs_q;
    fs_wdata_d   = fs_wdata_q;
    data_d       = data_q;
    case (state_q)
      IDLE: if (iq_req) begin
        state_d      = ARB;
        fs_address_d = iq_address[19:1];
        fs_rnw_d     = iq_rnw;
        fs_nbs_d     = iq_address[0] ? 2'b01 : 2'b10;
        fs_wdata_d   = {data_from_iq, data_from_iq};
      end
      ARB: state_d = fs_gnt ? ACCESS : to_fire ? ACK : ARB;
      ACCESS: begin
        state_d = (fs_ack || to_fire) ? ACK : ACCESS;
        // fs_nbs_q[0] high means the high byte lane is selected
        if (fs_rnw_q && fs_ack) data_d = fs_nbs_q[0] ? fs_rdata[15:8] : fs_rdata[7:0];
      end
      default: state_d = IDLE;
    endcase
    if (fs_rnw_q && to_fire) data_d = 8'hFF;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      fs_address_q <= 19'h0;
      fs_rnw_q     <= 1'b1;
      fs_nbs_q     <= 2'b11;
      fs_wdata_q   <= 16'h0;
      data_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      fs_address_q <= fs_address_d;
      fs_rnw_q     <= fs_rnw_d;
      fs_nbs_q     <= fs_nbs_d;
      fs_wdata_q   <= fs_wdata_d;
      data_q       <= data_d;
    end
  end
  assign fs_req     = state_q == ARB || state_q == ACCESS;
  assign iq_busy    = state_q != IDLE;
  assign iq_ack     = state_q == ACK;
  assign fs_address = fs_address_q;
  assign fs_rnw     = fs_rnw_q;
  assign fs_nbs     = fs_nbs_q;
  assign fs_wdata   = fs_wdata_q;
  assign data_to_iq = data_q;
endmodule

// File: tb/tb_frame_store_iq.sv
// tb_frame_store_iq: directed self-checking bench for frame_store_iq.
module tb_frame_store_iq;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        iq_req = 1'b0;
  logic        iq_ack;
  logic [19:0] iq_address = 20'h0;
  logic        iq_rnw = 1'b1;
  logic [7:0]  data_from_iq = 8'h00;
  logic [7:0]  data_to_iq;
  logic        iq_busy;
  logic        fs_req;
  logic        fs_gnt = 1'b0;
  logic [18:0] fs_address;
  logic        fs_rnw;
  logic [1:0]  fs_nbs;
  logic [15:0] fs_wdata;
  logic [15:0] fs_rdata = 16'h0;
  logic        fs_ack = 1'b0;
  logic        iq_err;
  logic        iq_err_clr = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_store_iq dut (
    .clk(clk), .nreset(nreset), .iq_req(iq_req), .iq_ack(iq_ack),
    .iq_address(iq_address), .iq_rnw(iq_rnw), .data_from_iq(data_from_iq),
    .data_to_iq(data_to_iq), .iq_busy(iq_busy), .fs_req(fs_req), .fs_gnt(fs_gnt),
    .fs_address(fs_address), .fs_rnw(fs_rnw), .fs_nbs(fs_nbs), .fs_wdata(fs_wdata),
    .fs_rdata(fs_rdata), .fs_ack(fs_ack), .iq_err(iq_err), .iq_err_clr(iq_err_clr)
  );

  task automatic idle_bus();
    iq_req = 1'b0;
    fs_gnt = 1'b0;
    fs_ack = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({iq_ack, iq_busy, fs_req, iq_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got ack/busy/req/err=%b expected 0000", {iq_ack, iq_busy, fs_req, iq_err});
    end
    checks++;
    if ({data_to_iq, fs_address, fs_rnw, fs_nbs, fs_wdata} !== {8'h00, 19'h0, 1'b1, 2'b11, 16'h0}) begin
      errors++;
      $display("FAIL reset_data: got d=%h a=%h rnw=%b nbs=%b w=%h expected 00/0/1/11/0",
               data_to_iq, fs_address, fs_rnw, fs_nbs, fs_wdata);
    end
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_latency();
    int lat;
    iq_address = 20'h00001; iq_rnw = 1'b1; fs_rdata = 16'hA55A;
    fs_gnt = 1'b1; fs_ack = 1'b1; iq_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({fs_req, iq_busy, iq_ack} !== 3'b110) begin
      errors++;
      $display("FAIL read_arb_ctrl: got req/busy/ack=%b expected 110", {fs_req, iq_busy, iq_ack});
    end
    checks++;
    if ({fs_address, fs_rnw, fs_nbs} !== {19'h0, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL read_bus: got a=%h rnw=%b nbs=%b expected 0/1/01", fs_address, fs_rnw, fs_nbs);
    end
    lat = 1;
    while (iq_ack !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL read_latency: got %0d expected 3", lat);
    end
    checks++;
    if (data_to_iq !== 8'hA5) begin
      errors++;
      $display("FAIL read_data_hi: got %h expected a5", data_to_iq);
    end
    checks++;
    if (fs_req !== 1'b0) begin
      errors++;
      $display("FAIL ack_fs_req: got %b expected 0", fs_req);
    end
    idle_bus();
    @(negedge clk);
    checks++;
    if ({iq_ack, iq_busy} !== 2'b00) begin
      errors++;
      $display("FAIL ack_one_cycle: got ack/busy=%b expected 00", {iq_ack, iq_busy});
    end
  endtask

  task automatic test_write();
    int lat;
    iq_address = 20'h12340; iq_rnw = 1'b0; data_from_iq = 8'h3C; fs_rdata = 16'hFFFF;
    iq_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({fs_address, fs_rnw, fs_nbs, fs_wdata} !== {19'h091A0, 1'b0, 2'b10, 16'h3C3C}) begin
      errors++;
      $display("FAIL write_bus: got a=%h rnw=%b nbs=%b w=%h expected 091a0/0/10/3c3c",
               fs_address, fs_rnw, fs_nbs, fs_wdata);
    end
    fs_gnt = 1'b1;
    @(negedge clk);
    fs_ack = 1'b1;
    lat = 0;
    while (iq_ack !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL write_ack_wait: got %0d cycles expected 1", lat);
    end
    checks++;
    if (data_to_iq !== 8'hA5) begin
      errors++;
      $display("FAIL write_keeps_data: got %h expected a5", data_to_iq);
    end
    idle_bus();
    @(negedge clk);
  endtask

  task automatic test_arb_hold();
    int bad;
    int lat;
    iq_address = 20'h00000; iq_rnw = 1'b1; fs_rdata = 16'h1234;
    iq_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (iq_busy !== 1'b1 || iq_ack !== 1'b0 || fs_req !== 1'b1) bad++;
      fs_ack = (i == 4);
    end
    fs_ack = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL arb_hold: got %0d bad cycles expected 0", bad);
    end
    fs_gnt = 1'b1;
    @(negedge clk);
    fs_gnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({fs_req, iq_busy, iq_ack} !== 3'b110) begin
      errors++;
      $display("FAIL access_hold: got req/busy/ack=%b expected 110", {fs_req, iq_busy, iq_ack});
    end
    fs_ack = 1'b1;
    lat = 0;
    while (iq_ack !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 1 || data_to_iq !== 8'h34) begin
      errors++;
      $display("FAIL arb_read: got wait=%0d data=%h expected 1/34", lat, data_to_iq);
    end
    idle_bus();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    iq_address = 20'h00003; iq_rnw = 1'b1; fs_rdata = 16'h7788;
    fs_gnt = 1'b1; iq_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (fs_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_access: got fs_req=%b expected 1", fs_req);
    end
    #2;
    nreset = 1'b0;
    iq_req = 1'b0;
    fs_ack = 1'b1;
    #1;
    checks++;
    if ({fs_req, iq_busy, iq_ack} !== 3'b000) begin
      errors++;
      $display("FAIL mid_async_drop: got req/busy/ack=%b expected 000", {fs_req, iq_busy, iq_ack});
    end
    @(negedge clk);
    checks++;
    if ({iq_ack, data_to_iq, fs_nbs} !== {1'b0, 8'h00, 2'b11}) begin
      errors++;
      $display("FAIL mid_reset_state: got ack=%b d=%h nbs=%b expected 0/00/11", iq_ack, data_to_iq, fs_nbs);
    end
    nreset = 1'b1;
    idle_bus();
    @(negedge clk);
    iq_address = 20'h00002; fs_rdata = 16'hBEEF;
    fs_gnt = 1'b1; fs_ack = 1'b1; iq_req = 1'b1;
    lat = 0;
    while (iq_ack !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3 || data_to_iq !== 8'hEF || fs_address !== 19'h1) begin
      errors++;
      $display("FAIL post_reset_read: got lat=%0d d=%h a=%h expected 3/ef/1", lat, data_to_iq, fs_address);
    end
    idle_bus();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    iq_address = 20'h00000; iq_rnw = 1'b1; fs_rdata = 16'h00C3;
    iq_req = 1'b1;
    @(negedge clk);
    lat = 0;
    while (iq_ack !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
`ifdef IQ_TIMEOUT_EN
    checks++;
    if (lat !== 256 || data_to_iq !== 8'hFF || iq_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout: got lat=%0d d=%h err=%b expected 256/ff/1", lat, data_to_iq, iq_err);
    end
    idle_bus();
    repeat (3) @(negedge clk);
    checks++;
    if (iq_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", iq_err);
    end
    iq_err_clr = 1'b1;
    @(negedge clk);
    iq_err_clr = 1'b0;
    checks++;
    if (iq_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", iq_err);
    end
`else
    checks++;
    if (lat !== 300 || iq_busy !== 1'b1 || iq_err !== 1'b0) begin
      errors++;
      $display("FAIL wait_forever: got lat=%0d busy=%b err=%b expected 300/1/0", lat, iq_busy, iq_err);
    end
    iq_err_clr = 1'b1;
    fs_gnt = 1'b1;
    fs_ack = 1'b1;
    lat = 0;
    while (iq_ack !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    iq_err_clr = 1'b0;
    checks++;
    if (lat !== 2 || data_to_iq !== 8'hC3 || iq_err !== 1'b0) begin
      errors++;
      $display("FAIL late_grant: got lat=%0d d=%h err=%b expected 2/c3/0", lat, data_to_iq, iq_err);
    end
    idle_bus();
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write();
    test_arb_hold();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
